// File: rtl/stepper_bus_pkg.sv
// Shared definitions for the SPI bus responder: register map, STATUS bits,
// shift-engine state encoding and the byte-enable merge helper.
package stepper_bus_pkg;

  localparam int unsigned FRAME_BITS_DEFAULT = 40;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_TX_HI  = 2'd1;
  localparam logic [1:0] REG_TX_LO  = 2'd2;
  localparam logic [1:0] REG_CLKDIV = 2'd3;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_OVR  = 2;
  localparam int unsigned ST_IE   = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } spi_state_t;

  function automatic logic [31:0] apply_be(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int unsigned i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-3 frame engine: SETUP/SHIFT/HOLD sequencing, SCK divider,
// MSB-first transmit and receive shift registers.
module spi_shift_engine
  import stepper_bus_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            div,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx,
  output logic                  sck,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);
  localparam int unsigned HALVES = 2 * FRAME_BITS;
  localparam int unsigned HW     = $clog2(HALVES);

  spi_state_t            state, state_next;
  logic [7:0]            cnt, div_l;
  logic [HW-1:0]         half;
  logic [FRAME_BITS-1:0] tx;
  logic                  cnt_end, last_half;

  assign cnt_end   = (cnt == div_l);
  assign last_half = (half == HW'(HALVES - 1));
  assign mosi      = tx[FRAME_BITS-1];

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      S_IDLE:  if (start) state_next = S_SETUP;
      S_SETUP: if (cnt_end) state_next = S_SHIFT;
      S_SHIFT: if (cnt_end && last_half) state_next = S_HOLD;
      S_HOLD: begin
        if (cnt_end) begin
          state_next = S_IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_l <= '0;
      half  <= '0;
      tx    <= '0;
      rx    <= '0;
      sck   <= 1'b1;
      cs_n  <= 1'b1;
      busy  <= 1'b0;
    end else begin
      cnt <= (state == S_IDLE || cnt_end) ? '0 : cnt + 8'd1;
      case (state)
        S_IDLE: begin
          if (start) begin
            div_l <= div;
            tx    <= frame;
            half  <= '0;
            cs_n  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_SETUP: if (cnt_end) sck <= 1'b0;
        S_SHIFT: begin
          // The first fall happens on SETUP exit without shifting, so bit
          // FRAME_BITS-1 is sampled on the first rise; the last half stays high.
          if (cnt_end) begin
            half <= half + HW'(1);
            if (!last_half) begin
              sck <= ~sck;
              if (sck) tx <= {tx[FRAME_BITS-2:0], 1'b0};
              else     rx <= {rx[FRAME_BITS-2:0], miso};
            end
          end
        end
        S_HOLD: begin
          if (cnt_end) begin
            cs_n <= 1'b1;
            busy <= 1'b0;
            tx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bus_spi_responder.sv
// CPU bus responder owning the SPI datagram, reply and divider registers.
// Optional interrupt output and STATUS.ie enabled by defining SPI_IRQ_EN.
module bus_spi_responder
  import stepper_bus_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int unsigned DIV_RESET  = 3
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        enable_in,
  input  logic        write_in,
  input  logic [3:0]  byte_e_in,
  input  logic [1:0]  addr_in,
  input  logic [31:0] data_in,
  output logic [31:0] r_data_out,
  input  logic        serial_in,
  output logic        sck_out,
  output logic        serial_out,
  output logic        cs_n_out,
  output logic        busy_out
`ifdef SPI_IRQ_EN
  ,
  output logic        irq_out
`endif
);
  localparam int unsigned HI_BITS = FRAME_BITS - 32;

  logic [HI_BITS-1:0]    tx_hi, rx_hi;
  logic [31:0]           tx_lo, rx_lo, tx_lo_next, rd_mux;
  logic [7:0]            clkdiv;
  logic                  done_f, ovr_f;
  logic                  wr, rd, st_wr, lo_wr, start;
  logic                  busy, eng_done;
  logic [FRAME_BITS-1:0] rx;
`ifdef SPI_IRQ_EN
  logic                  ie;
  assign irq_out = done_f & ie;
`endif

  assign busy_out = busy;

  always_comb begin
    wr         = enable_in & write_in;
    rd         = enable_in & ~write_in;
    st_wr      = wr && (addr_in == REG_STATUS) && byte_e_in[0];
    lo_wr      = wr && (addr_in == REG_TX_LO);
    start      = lo_wr && !busy;
    tx_lo_next = apply_be(tx_lo, data_in, byte_e_in);
    rd_mux     = '0;
    case (addr_in)
      REG_STATUS: begin
        rd_mux[ST_BUSY] = busy;
        rd_mux[ST_DONE] = done_f;
        rd_mux[ST_OVR]  = ovr_f;
`ifdef SPI_IRQ_EN
        rd_mux[ST_IE]   = ie;
`endif
      end
      REG_TX_HI:  rd_mux[HI_BITS-1:0] = rx_hi;
      REG_TX_LO:  rd_mux = rx_lo;
      REG_CLKDIV: rd_mux[7:0] = clkdiv;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_data_out <= '0;
      tx_hi      <= '0;
      tx_lo      <= '0;
      rx_hi      <= '0;
      rx_lo      <= '0;
      clkdiv     <= 8'(DIV_RESET);
      done_f     <= 1'b0;
      ovr_f      <= 1'b0;
`ifdef SPI_IRQ_EN
      ie         <= 1'b0;
`endif
    end else begin
      r_data_out <= rd ? rd_mux : '0;
      if (wr && addr_in == REG_TX_HI && byte_e_in[0]) tx_hi <= data_in[HI_BITS-1:0];
      if (wr && addr_in == REG_CLKDIV && byte_e_in[0]) clkdiv <= data_in[7:0];
      if (start) tx_lo <= tx_lo_next;
      // Setting terms are OR-ed after the clear so a same-edge set wins.
      done_f <= eng_done | (done_f & ~(st_wr & data_in[ST_DONE]));
      ovr_f  <= (lo_wr & busy) | (ovr_f & ~(st_wr & data_in[ST_OVR]));
      if (eng_done) {rx_hi, rx_lo} <= rx;
`ifdef SPI_IRQ_EN
      if (st_wr) ie <= data_in[ST_IE];
`endif
    end
  end

  spi_shift_engine #(.FRAME_BITS(FRAME_BITS)) u_engine (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .start (start),
    .div   (clkdiv),
    .frame ({tx_hi, tx_lo_next}),
    .busy  (busy),
    .done  (eng_done),
    .rx    (rx),
    .sck   (sck_out),
    .cs_n  (cs_n_out),
    .mosi  (serial_out),
    .miso  (serial_in)
  );

endmodule

// File: tb/tb_bus_spi_responder.sv
// Directed bench for bus_spi_responder: register vector table plus transfer
// sequences with serial_out looped back to serial_in.
module tb_bus_spi_responder;
  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        enable_in = 1'b0;
  logic        write_in = 1'b0;
  logic [3:0]  byte_e_in = '0;
  logic [1:0]  addr_in = '0;
  logic [31:0] data_in = '0;
  logic [31:0] r_data_out;
  logic        serial_in;
  logic        sck_out, serial_out, cs_n_out, busy_out;
`ifdef SPI_IRQ_EN
  logic        irq_out;
  localparam logic [31:0] IE_RB = 32'h8;
`else
  localparam logic [31:0] IE_RB = 32'h0;
`endif

  int errors = 0;
  int checks = 0;
  int rises = 0;
  logic [39:0] cap = '0;

  assign serial_in = serial_out;

  bus_spi_responder #(.FRAME_BITS(40), .DIV_RESET(3)) dut (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .enable_in  (enable_in),
    .write_in   (write_in),
    .byte_e_in  (byte_e_in),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .r_data_out (r_data_out),
    .serial_in  (serial_in),
    .sck_out    (sck_out),
    .serial_out (serial_out),
    .cs_n_out   (cs_n_out),
    .busy_out   (busy_out)
`ifdef SPI_IRQ_EN
    ,
    .irq_out    (irq_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  always @(posedge sck_out) begin
    rises = rises + 1;
    cap   = {cap[38:0], serial_out};
  end

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic wr, input logic [1:0] a, input logic [3:0] be,
                        input logic [31:0] d, output logic [31:0] q);
    @(negedge clk_in);
    enable_in = 1'b1; write_in = wr; addr_in = a; byte_e_in = be; data_in = d;
    @(negedge clk_in);
    enable_in = 1'b0; write_in = 1'b0; byte_e_in = '0;
    q = r_data_out;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] q;
    bus_op(1'b1, a, be, d, q);
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] q;
    bus_op(1'b0, a, 4'h0, 32'h0, q);
    check(name, q, exp);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy_out === 1'b1 && n < 20000) begin
      n++;
      @(negedge clk_in);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, r0;
    logic [31:0] q;

    vecs[0]  = '{1'b0, 2'd0, 4'h0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 2'd3, 4'h0, 32'h0,         32'h3};
    vecs[2]  = '{1'b1, 2'd3, 4'h2, 32'h0000_0509, 32'h0};
    vecs[3]  = '{1'b0, 2'd3, 4'h0, 32'h0,         32'h3};
    vecs[4]  = '{1'b1, 2'd3, 4'hF, 32'hABCD_EF07, 32'h0};
    vecs[5]  = '{1'b0, 2'd3, 4'h0, 32'h0,         32'h7};
    vecs[6]  = '{1'b1, 2'd3, 4'h1, 32'h0000_0003, 32'h0};
    vecs[7]  = '{1'b1, 2'd1, 4'h1, 32'hFFFF_FF6C, 32'h0};
    vecs[8]  = '{1'b0, 2'd1, 4'h0, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 2'd2, 4'h0, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 2'd0, 4'h1, 32'h0000_0008, 32'h0};
    vecs[11] = '{1'b0, 2'd0, 4'h0, 32'h0,         IE_RB};
    vecs[12] = '{1'b1, 2'd0, 4'h1, 32'h0000_0000, 32'h0};
    vecs[13] = '{1'b0, 2'd0, 4'h0, 32'h0,         32'h0};

    // Reset
    repeat (3) @(negedge clk_in);
    check("rst_cs_n", cs_n_out, 1'b1);
    check("rst_sck", sck_out, 1'b1);
    check("rst_busy", busy_out, 1'b0);
    check("rst_mosi", serial_out, 1'b0);
    check("rst_rdata", r_data_out, 32'h0);
    reset_n_in = 1'b1;
    @(negedge clk_in);

    // Register vectors
    for (int i = 0; i < 14; i++) begin
      bus_op(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].data, q);
      check($sformatf("vec%0d", i), q, vecs[i].exp);
    end

    // Loopback transfer, D=4
    r0 = rises;
    wr_reg(2'd2, 4'hF, 32'h0001_01D5);
    wait_busy(n);
    check("lb_busy_cycles", n, 328);
    check("lb_sck_rises", rises - r0, 40);
    check("lb_mosi_frame", cap, 40'h6C_0001_01D5);
    rd_chk("lb_rx_hi", 2'd1, 32'h6C);
    rd_chk("lb_rx_lo", 2'd2, 32'h0001_01D5);
    rd_chk("lb_status", 2'd0, 32'h2);
`ifdef SPI_IRQ_EN
    check("lb_irq_ie0", irq_out, 1'b0);
`endif

    // Overrun 10 cycles after start
    wr_reg(2'd0, 4'h1, 32'h2);
    rd_chk("ovr_clr_done", 2'd0, 32'h0);
    wr_reg(2'd2, 4'hF, 32'h1234_5678);
    repeat (8) @(negedge clk_in);
    wr_reg(2'd2, 4'hF, 32'hFFFF_FFFF);
    rd_chk("ovr_status_mid", 2'd0, 32'h5);
    wait_busy(n);
    check("ovr_busy_rest", n, 316);
    check("ovr_mosi_frame", cap, 40'h6C_1234_5678);
    rd_chk("ovr_rx_lo", 2'd2, 32'h1234_5678);
    rd_chk("ovr_status_end", 2'd0, 32'h6);
    wr_reg(2'd0, 4'h1, 32'h6);
    rd_chk("ovr_w1c", 2'd0, 32'h0);

    // Overrun landing on the final HOLD edge
    wr_reg(2'd2, 4'hF, 32'hCAFE_F00D);
    repeat (326) @(negedge clk_in);
    check("hold_edge_busy_before", busy_out, 1'b1);
    wr_reg(2'd2, 4'hF, 32'h0000_0000);
    check("hold_edge_busy_after", busy_out, 1'b0);
    rd_chk("hold_edge_status", 2'd0, 32'h6);
    check("hold_edge_frame", cap, 40'h6C_CAFE_F00D);
    rd_chk("hold_edge_rx_lo", 2'd2, 32'hCAFE_F00D);
    wr_reg(2'd0, 4'h1, 32'h6);

    // Divider: D=1, then CLKDIV change mid-transfer
    wr_reg(2'd3, 4'h1, 32'h0);
    r0 = rises;
    wr_reg(2'd2, 4'hF, 32'h0F0F_0F0F);
    wait_busy(n);
    check("div0_busy", n, 82);
    check("div0_rises", rises - r0, 40);
    check("div0_frame", cap, 40'h6C_0F0F_0F0F);
    wr_reg(2'd2, 4'hF, 32'h33CC_33CC);
    wr_reg(2'd3, 4'h1, 32'h9);
    wait_busy(n);
    check("div_mid_busy", n, 80);
    check("div_mid_frame", cap, 40'h6C_33CC_33CC);
    rd_chk("div_readback", 2'd3, 32'h9);
    r0 = rises;
    wr_reg(2'd2, 4'hF, 32'h0000_0000);
    wait_busy(n);
    check("div9_busy", n, 820);
    check("div9_rises", rises - r0, 40);
    check("div9_frame", cap, 40'h6C_0000_0000);

    // Byte enables over TX_LO=0
    wr_reg(2'd1, 4'h1, 32'hA5);
    wr_reg(2'd2, 4'h1, 32'hFFFF_FFFF);
    wait_busy(n);
    check("be_busy", n, 820);
    check("be_frame", cap, 40'hA5_0000_00FF);
    rd_chk("be_rx_lo", 2'd2, 32'h0000_00FF);
    rd_chk("be_rx_hi", 2'd1, 32'hA5);

    // Asynchronous reset mid-transfer
    wr_reg(2'd2, 4'hF, 32'h1234_5678);
    repeat (98) @(negedge clk_in);
    check("arst_pre_busy", busy_out, 1'b1);
    check("arst_pre_cs_n", cs_n_out, 1'b0);
    #2 reset_n_in = 1'b0;
    #1;
    check("arst_cs_n", cs_n_out, 1'b1);
    check("arst_sck", sck_out, 1'b1);
    check("arst_busy", busy_out, 1'b0);
    check("arst_mosi", serial_out, 1'b0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    rd_chk("arst_rx_lo", 2'd2, 32'h0);
    rd_chk("arst_status", 2'd0, 32'h0);
    rd_chk("arst_clkdiv", 2'd3, 32'h3);

`ifdef SPI_IRQ_EN
    wr_reg(2'd0, 4'h1, 32'h8);
    rd_chk("irq_ie_set", 2'd0, 32'h8);
    wr_reg(2'd2, 4'hF, 32'h0);
    repeat (327) @(negedge clk_in);
    check("irq_before_done", irq_out, 1'b0);
    @(negedge clk_in);
    check("irq_busy_low", busy_out, 1'b0);
    check("irq_rise", irq_out, 1'b1);
    wr_reg(2'd0, 4'h1, 32'hA);
    check("irq_w1c_drop", irq_out, 1'b0);
    rd_chk("irq_status_after", 2'd0, 32'h8);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_spi_responder.md
Name: bus_spi_responder

Overview:
- Memory-mapped SPI master peripheral that acts as a responder on the CPU data bus, decoded by the top level alongside RAM and IO RAM.
- The CPU writes a 40-bit motor-driver datagram into registers; the block shifts it out over SPI mode 3 and captures the driver's 40-bit reply for readback.
- It replaces hard-wired SPI glue so firmware owns driver configuration.

Parameters:
- FRAME_BITS, 40, SPI datagram length in bits (MSB first).
- DIV_RESET, 3, reset value of the CLKDIV register. SCK half-period is CLKDIV+1 clk_in cycles.

Ports:
- clk_in  input  1  system clock (25 MHz).
- reset_n_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  bus select for this block, from the top-level address decode.
- write_in  input  1  1 = write cycle, 0 = read cycle (qualified by enable_in).
- byte_e_in  input  4  byte enables for writes.
- addr_in  input  2  word index, taken from DADDR[3:2].
- data_in  input  32  write data from the CPU.
- r_data_out  output  32  registered read data.
- serial_in  input  1  SDO from the driver.
- sck_out  output  1  SPI clock; idles high.
- serial_out  output  1  SDI to the driver.
- cs_n_out  output  1  chip select, active low.
- busy_out  output  1  transfer in progress.

Behaviour:
- Register map, by word index:
  - 0 STATUS: [0] busy (read-only); [1] done (sticky, write-1-to-clear); [2] ovr (sticky, write-1-to-clear).
  - 1 TX_HI[7:0] on write; RX_HI[7:0] on read.
  - 2 TX_LO[31:0] on write; RX_LO on read. A write starts a transfer.
  - 3 CLKDIV[7:0].
  - Unused bits read 0.
- Writes:
  - Only bytes with byte_e_in set are updated.
  - A TX_LO write starts a transfer regardless of which bytes are enabled; unenabled bytes keep their old value.
- Reads:
  - r_data_out updates one edge after a cycle with enable_in=1 and write_in=0.
  - After a write cycle or an unselected cycle, r_data_out is 0, so the top level can OR read data from several responders.
- Reset values: r_data_out=0, sck_out=1, cs_n_out=1, serial_out=0, busy_out=0, all registers 0, CLKDIV=DIV_RESET.
- FSM states and transitions (D = latched CLKDIV+1):
  - IDLE → SETUP on the edge that accepts a TX_LO write. At that edge: cs_n_out goes low, busy_out goes high, CLKDIV is latched into D, and the shift register loads {TX_HI, TX_LO}.
  - SETUP: lasts D cycles with sck_out high; serial_out presents bit 39.
  - SHIFT: lasts 80*D cycles. sck_out falls, then rises, every D cycles. serial_out changes after each falling edge. serial_in is sampled on each rising edge of sck_out.
  - HOLD: lasts D cycles with sck_out high.
  - HOLD → IDLE: cs_n_out goes high, busy_out goes low, RX_HI/RX_LO are updated, done is set.
  - Total busy time is exactly 82*D cycles (328 cycles at reset).
- Boundary conditions:
  - TX_LO write while busy (including on the final HOLD edge): the write is ignored, ovr is set, and the transfer in flight is unaffected.
  - CLKDIV write during a transfer: takes effect on the next transfer.
  - done set and a W1C clear on the same edge: set wins.
  - Reset asserted mid-transfer: all outputs return immediately to their reset values; partial RX data is discarded.

Optional Feature:
- Macro: SPI_IRQ_EN.
- With SPI_IRQ_EN defined:
  - Adds output irq_out, 1 bit, reset 0.
  - irq_out = done & ie, where ie is STATUS[3], read/write, reset 0.
- Without SPI_IRQ_EN:
  - No irq_out port.
  - STATUS[3] reads 0 and ignores writes.

Decomposition:
- Package stepper_bus_pkg contains:
  - register word indices;
  - STATUS bit positions;
  - FSM state encoding;
  - FRAME_BITS default.
- Sub-module spi_shift_engine contains the SETUP/SHIFT/HOLD FSM, divider counter and shift register.
  - Inputs: start, div, frame.
  - Outputs: busy, done pulse, rx frame, SPI pins.
- bus_spi_responder keeps the register file and the bus decode.

Test Plan:
1. Reset check: hold reset_n_in=0, then release → cs_n_out=1, sck_out=1, busy_out=0, STATUS read returns 0x0, CLKDIV read returns 0x3.
2. Loopback: serial_out tied to serial_in; write TX_HI=0x6C, then TX_LO=0x000101D5 → exactly 40 rising edges on sck_out, busy high 328 cycles, RX_HI reads 0x6C, RX_LO reads 0x000101D5, STATUS reads 0x2.
3. Overrun: write TX_LO again 10 cycles after a start → the frame in flight is unchanged and STATUS reads 0x5 mid-transfer. Then write 0x6 to STATUS after completion → STATUS reads 0x0.
4. Divider: write CLKDIV=0, then start a transfer → SCK period is 2 cycles and busy lasts 82 cycles. Write CLKDIV=9 mid-transfer → the current transfer is unaffected; the next transfer's busy lasts 820 cycles.
5. Byte enables and reset: write TX_LO=0xFFFFFFFF with byte_e_in=0001 over old value 0 → shifted low word is 0x000000FF. Assert reset at cycle 100 of that transfer → cs_n_out=1 and sck_out=1 with no clock edge required.
6. With SPI_IRQ_EN: set ie=1 and complete a transfer → irq_out rises on the same edge as done; write-1-to-clear of done drops irq_out on the next edge.
